// File: rtl/mem_access.sv
// Memory-access pipeline stage: accepts one instruction per handshake from execute,
// runs at most one req/ack data-memory transaction and hands a registered bundle to write-back.
`ifndef COND_FLOW
`define COND_FLOW 2'b01
`endif
`ifndef COND_EMPTY
`define COND_EMPTY 2'b00
`endif

module mem_access #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_IR,
  input  logic [31:0] ex_Z,
  input  logic [31:0] ex_B,
  input  logic [31:0] ex_HI,
  input  logic [31:0] ex_LO,
  input  logic        flush,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        dmem_err,
  output logic [31:0] me_IR,
  output logic [31:0] me_Z,
  output logic [31:0] me_MEM,
  output logic [31:0] me_HI,
  output logic [31:0] me_LO,
  output logic [1:0]  me_cond
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, ACCESS} state_e;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

  typedef struct packed {
    logic  is_load;
    logic  is_store;
    size_e size;
    logic  sext;
  } mem_op_t;

  function automatic mem_op_t decode(input logic [5:0] opcode);
    mem_op_t op;
    op = '{is_load: 1'b0, is_store: 1'b0, size: SZ_WORD, sext: 1'b0};
    case (opcode)
      6'b100000: op = '{is_load: 1'b1, is_store: 1'b0, size: SZ_BYTE, sext: 1'b1}; // LB
      6'b100001: op = '{is_load: 1'b1, is_store: 1'b0, size: SZ_HALF, sext: 1'b1}; // LH
      6'b100011: op = '{is_load: 1'b1, is_store: 1'b0, size: SZ_WORD, sext: 1'b0}; // LW
      6'b100100: op = '{is_load: 1'b1, is_store: 1'b0, size: SZ_BYTE, sext: 1'b0}; // LBU
      6'b100101: op = '{is_load: 1'b1, is_store: 1'b0, size: SZ_HALF, sext: 1'b0}; // LHU
      6'b101000: op = '{is_load: 1'b0, is_store: 1'b1, size: SZ_BYTE, sext: 1'b0}; // SB
      6'b101001: op = '{is_load: 1'b0, is_store: 1'b1, size: SZ_HALF, sext: 1'b0}; // SH
      6'b101011: op = '{is_load: 1'b0, is_store: 1'b1, size: SZ_WORD, sext: 1'b0}; // SW
      default:   op = '{is_load: 1'b0, is_store: 1'b0, size: SZ_WORD, sext: 1'b0};
    endcase
    return op;
  endfunction

  function automatic logic [31:0] fmt_load(input mem_op_t op, input logic [1:0] lane,
                                           input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (op.size)
      SZ_BYTE: r = op.sext ? {{24{b[7]}}, b} : {24'b0, b};
      SZ_HALF: r = op.sext ? {{16{h[15]}}, h} : {16'b0, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flushed_q, flushed_d;
  logic [31:0]   ir_q, ir_d, z_q, z_d, hi_q, hi_d, lo_q, lo_d;
  logic          req_q, req_d, we_q, we_d, err_q, err_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   me_ir_q, me_ir_d, me_z_q, me_z_d, me_mem_q, me_mem_d;
  logic [31:0]   me_hi_q, me_hi_d, me_lo_q, me_lo_d;
  logic [1:0]    me_cond_q, me_cond_d;

  mem_op_t ex_op, acc_op;
  logic    ex_fire, misaligned, discard;

  assign ex_ready   = (state_q == IDLE) & ~rst;
  assign ex_fire    = ex_valid & ex_ready;
  assign ex_op      = decode(ex_IR[31:26]);
  assign acc_op     = decode(ir_q[31:26]);
  assign misaligned = ((ex_op.size == SZ_WORD) && (ex_Z[1:0] != 2'b00)) ||
                      ((ex_op.size == SZ_HALF) && ex_Z[0]);
  assign discard    = flushed_q | flush;

  // NOTE: every signal gets its hold/default value first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    flushed_d = flushed_q;
    ir_d      = ir_q;
    z_d       = z_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    me_ir_d   = me_ir_q;
    me_z_d    = me_z_q;
    me_mem_d  = me_mem_q;
    me_hi_d   = me_hi_q;
    me_lo_d   = me_lo_q;
    err_d     = 1'b0;
    me_cond_d = `COND_EMPTY;

    case (state_q)
      IDLE: begin
        if (ex_fire && !flush) begin
          if (!ex_op.is_load && !ex_op.is_store) begin
            me_ir_d   = ex_IR;
            me_z_d    = ex_Z;
            me_mem_d  = '0;
            me_hi_d   = ex_HI;
            me_lo_d   = ex_LO;
            me_cond_d = `COND_FLOW;
          end else if (misaligned) begin
            err_d = 1'b1;
          end else begin
            state_d   = ACCESS;
            cnt_d     = '0;
            flushed_d = 1'b0;
            ir_d      = ex_IR;
            z_d       = ex_Z;
            hi_d      = ex_HI;
            lo_d      = ex_LO;
            req_d     = 1'b1;
            we_d      = ex_op.is_store;
            addr_d    = {ex_Z[31:2], 2'b00};
            be_d      = 4'b1111;
            wdata_d   = ex_B;
            if (ex_op.is_store) begin
              case (ex_op.size)
                SZ_BYTE: begin be_d = 4'b0001 << ex_Z[1:0];              wdata_d = {4{ex_B[7:0]}};  end
                SZ_HALF: begin be_d = ex_Z[1] ? 4'b1100 : 4'b0011;       wdata_d = {2{ex_B[15:0]}}; end
                default: begin be_d = 4'b1111;                           wdata_d = ex_B;            end
              endcase
            end
          end
        end
      end

      ACCESS: begin
        flushed_d = discard;
        // Ack takes priority over the terminal count; a flushed result still lets the bus finish.
        if (dmem_ack || cnt_q == CNT_LAST) begin
          state_d = IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          be_d    = '0;
          wdata_d = '0;
          if (!dmem_ack) begin
            err_d = 1'b1;
          end else if (!discard) begin
            me_ir_d   = ir_q;
            me_z_d    = z_q;
            me_mem_d  = acc_op.is_load ? fmt_load(acc_op, z_q[1:0], dmem_rdata) : '0;
            me_hi_d   = hi_q;
            me_lo_d   = lo_q;
            me_cond_d = `COND_FLOW;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so all flops sample their _d values together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      flushed_q <= 1'b0;
      ir_q      <= '0;
      z_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      me_ir_q   <= '0;
      me_z_q    <= '0;
      me_mem_q  <= '0;
      me_hi_q   <= '0;
      me_lo_q   <= '0;
      me_cond_q <= `COND_EMPTY;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      flushed_q <= flushed_d;
      ir_q      <= ir_d;
      z_q       <= z_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      me_ir_q   <= me_ir_d;
      me_z_q    <= me_z_d;
      me_mem_q  <= me_mem_d;
      me_hi_q   <= me_hi_d;
      me_lo_q   <= me_lo_d;
      me_cond_q <= me_cond_d;
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign dmem_err   = err_q;
  assign me_IR      = me_ir_q;
  assign me_Z       = me_z_q;
  assign me_MEM     = me_mem_q;
  assign me_HI      = me_hi_q;
  assign me_LO      = me_lo_q;
  assign me_cond    = me_cond_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: transaction-level model sets expected outputs per cycle,
// a negedge process compares them, and literal checks pin the key results.
`ifndef COND_FLOW
`define COND_FLOW 2'b01
`endif
`ifndef COND_EMPTY
`define COND_EMPTY 2'b00
`endif

module tb_mem_access;
  localparam int TIMEOUT = 4;
  localparam int K_NONE = 0, K_LD = 1, K_ST = 2;

  logic        clk = 1'b0;
  logic        rst, ex_valid, ex_ready, flush;
  logic [31:0] ex_IR, ex_Z, ex_B, ex_HI, ex_LO;
  logic        dmem_req, dmem_we, dmem_ack, dmem_err;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic [31:0] me_IR, me_Z, me_MEM, me_HI, me_LO;
  logic [1:0]  me_cond;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_IR(ex_IR), .ex_Z(ex_Z), .ex_B(ex_B), .ex_HI(ex_HI), .ex_LO(ex_LO),
    .flush(flush), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .dmem_err(dmem_err), .me_IR(me_IR), .me_Z(me_Z),
    .me_MEM(me_MEM), .me_HI(me_HI), .me_LO(me_LO), .me_cond(me_cond)
  );

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  // Expected outputs after the most recent rising edge.
  logic        exp_ready, exp_req, exp_we, exp_err;
  logic [31:0] exp_addr, exp_wdata, exp_ir, exp_z, exp_mem, exp_hi, exp_lo;
  logic [3:0]  exp_be;
  logic [1:0]  exp_cond;

  int          req_cycles, err_pulses;
  logic        snap_we;
  logic [3:0]  snap_be;
  logic [31:0] snap_addr, snap_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("ex_ready", ex_ready, exp_ready);
      check("dmem_req", dmem_req, exp_req);
      check("dmem_err", dmem_err, exp_err);
      check("me_cond",  me_cond,  exp_cond);
      check("me_IR",    me_IR,    exp_ir);
      check("me_Z",     me_Z,     exp_z);
      check("me_MEM",   me_MEM,   exp_mem);
      check("me_HI",    me_HI,    exp_hi);
      check("me_LO",    me_LO,    exp_lo);
      if (exp_req) begin
        check("dmem_we",    dmem_we,    exp_we);
        check("dmem_addr",  dmem_addr,  exp_addr);
        check("dmem_be",    dmem_be,    exp_be);
        check("dmem_wdata", dmem_wdata, exp_wdata);
      end
      if (dmem_req) begin
        req_cycles++;
        snap_we    = dmem_we;
        snap_be    = dmem_be;
        snap_addr  = dmem_addr;
        snap_wdata = dmem_wdata;
      end
      if (dmem_err) err_pulses++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void decode(input logic [31:0] ir, output int kind, output int size,
                                 output bit sgn);
    kind = K_NONE; size = 4; sgn = 1'b0;
    case (ir[31:26])
      6'b100000: begin kind = K_LD; size = 1; sgn = 1'b1; end
      6'b100001: begin kind = K_LD; size = 2; sgn = 1'b1; end
      6'b100011: begin kind = K_LD; size = 4; end
      6'b100100: begin kind = K_LD; size = 1; end
      6'b100101: begin kind = K_LD; size = 2; end
      6'b101000: begin kind = K_ST; size = 1; end
      6'b101001: begin kind = K_ST; size = 2; end
      6'b101011: begin kind = K_ST; size = 4; end
      default:   kind = K_NONE;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] z,
                                             input int size, input bit sgn);
    logic [31:0] mask, v;
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    v = (rdata >> (8 * int'(z % 4))) & mask;
    if (sgn && v[8 * size - 1]) v = v | ~mask;
    return v;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      exp_err  = 1'b0;
      exp_cond = `COND_EMPTY;
    end
  endtask

  // ack_cyc/flush_cyc/rst_cyc: ACCESS cycle (1-based) whose closing edge sees the event; 0/-1 = never.
  task automatic issue(input logic [31:0] ir, input logic [31:0] z, input logic [31:0] b,
                       input logic [31:0] hi, input logic [31:0] lo, input int ack_cyc,
                       input logic [31:0] rdata, input bit flush_idle, input int flush_cyc,
                       input int rst_cyc);
    int kind, size, lane, be_i;
    bit sgn, flushed, ack;
    decode(ir, kind, size, sgn);
    ex_valid = 1'b1; ex_IR = ir; ex_Z = z; ex_B = b; ex_HI = hi; ex_LO = lo;
    flush = flush_idle;
    step();
    ex_valid = 1'b0; flush = 1'b0;
    exp_err = 1'b0; exp_cond = `COND_EMPTY;
    if (flush_idle) return;
    if (kind == K_NONE) begin
      exp_ir = ir; exp_z = z; exp_mem = 32'd0; exp_hi = hi; exp_lo = lo;
      exp_cond = `COND_FLOW;
      return;
    end
    if (int'(z % size) != 0) begin
      exp_err = 1'b1;
      return;
    end
    lane      = int'(z % 4);
    be_i      = ((1 << size) - 1) << lane;
    exp_ready = 1'b0;
    exp_req   = 1'b1;
    exp_we    = (kind == K_ST);
    exp_addr  = z - 32'(lane);
    exp_be    = (kind == K_ST) ? be_i[3:0] : 4'hF;
    if (kind == K_LD || size == 4) exp_wdata = (kind == K_ST) ? b : exp_wdata;
    if (kind == K_LD) exp_wdata = b;
    else if (size == 1) exp_wdata = {24'd0, b[7:0]} * 32'h0101_0101;
    else if (size == 2) exp_wdata = {16'd0, b[15:0]} * 32'h0001_0001;
    else exp_wdata = b;
    flushed = 1'b0;
    for (int c = 1; c <= TIMEOUT; c++) begin
      ack        = (c == ack_cyc);
      dmem_ack   = ack;
      dmem_rdata = ack ? rdata : $urandom;
      flush      = (c == flush_cyc);
      if (flush) flushed = 1'b1;
      rst        = (c == rst_cyc);
      ex_valid = 1'b1; ex_IR = $urandom; ex_Z = $urandom; ex_HI = $urandom; ex_LO = $urandom;
      step();
      dmem_ack = 1'b0; flush = 1'b0; ex_valid = 1'b0;
      if (rst) begin
        exp_ready = 1'b0; exp_req = 1'b0; exp_err = 1'b0; exp_cond = `COND_EMPTY;
        exp_ir = 0; exp_z = 0; exp_mem = 0; exp_hi = 0; exp_lo = 0;
        step();
        rst = 1'b0; exp_ready = 1'b1;
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        return;
      end
      if (ack || c == TIMEOUT) begin
        exp_ready = 1'b1;
        exp_req   = 1'b0;
        if (!ack) begin
          exp_err = 1'b1;
        end else if (!flushed) begin
          exp_ir = ir; exp_z = z; exp_hi = hi; exp_lo = lo;
          exp_mem  = (kind == K_LD) ? model_load(rdata, z, size, sgn) : 32'd0;
          exp_cond = `COND_FLOW;
        end
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ex_valid = 1'b0; flush = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'd0;
    ex_IR = 0; ex_Z = 0; ex_B = 0; ex_HI = 0; ex_LO = 0;
    exp_ready = 1'b0; exp_req = 1'b0; exp_we = 1'b0; exp_err = 1'b0;
    exp_addr = 0; exp_wdata = 0; exp_be = 0; exp_cond = `COND_EMPTY;
    exp_ir = 0; exp_z = 0; exp_mem = 0; exp_hi = 0; exp_lo = 0;
    req_cycles = 0; err_pulses = 0;
    step(); step();
    chk_en = 1'b1;
    check("reset_cond", me_cond, `COND_EMPTY);
    check("reset_req", dmem_req, 1'b0);
    step();
    rst = 1'b0; exp_ready = 1'b1;
    step();

    // ADDU: one-cycle latency, one-cycle FLOW
    issue(32'h0085_1021, 32'h12, 32'h0, 32'hAAAA_0001, 32'h5555_0002, 0, 0, 1'b0, -1, -1);
    check("addu_z", me_Z, 32'h12);
    check("addu_cond", me_cond, `COND_FLOW);
    idle(1);
    check("addu_cond_after", me_cond, `COND_EMPTY);

    // LB at 0x103, ack in the third ACCESS cycle
    req_cycles = 0;
    issue(32'h8082_0000, 32'h103, 32'h0, 32'h1, 32'h2, 3, 32'h80FF_0000, 1'b0, -1, -1);
    check("lb_mem", me_MEM, 32'hFFFF_FF80);
    check("lb_req_cycles", req_cycles, 3);
    check("lb_addr", snap_addr, 32'h100);
    check("lb_be", snap_be, 4'hF);
    idle(1);

    // LBU: same access, zero-extended
    issue(32'h9082_0000, 32'h103, 32'h0, 32'h3, 32'h4, 3, 32'h80FF_0000, 1'b0, -1, -1);
    check("lbu_mem", me_MEM, 32'h0000_0080);
    idle(1);

    // SH at 0x202, ack on first cycle
    issue(32'hA482_0000, 32'h202, 32'h1234_ABCD, 32'h5, 32'h6, 1, 0, 1'b0, -1, -1);
    check("sh_we", snap_we, 1'b1);
    check("sh_be", snap_be, 4'b1100);
    check("sh_wdata", snap_wdata, 32'hABCD_ABCD);
    check("sh_cond", me_cond, `COND_FLOW);
    idle(1);

    // Misaligned LW: error pulse, no bus access
    req_cycles = 0; err_pulses = 0;
    issue(32'h8C82_0000, 32'h201, 32'h0, 32'h7, 32'h8, 0, 0, 1'b0, -1, -1);
    check("lw_mis_err", dmem_err, 1'b1);
    idle(1);
    check("lw_mis_req_cycles", req_cycles, 0);
    check("lw_mis_err_pulses", err_pulses, 1);

    // LH upper half, LHU lower half, SB top lane
    issue(32'h8482_0000, 32'h102, 32'h0, 32'h9, 32'hA, 2, 32'h8001_1234, 1'b0, -1, -1);
    check("lh_mem", me_MEM, 32'hFFFF_8001);
    idle(1);
    issue(32'h9482_0000, 32'h100, 32'h0, 32'hB, 32'hC, 1, 32'h1234_F00D, 1'b0, -1, -1);
    check("lhu_mem", me_MEM, 32'h0000_F00D);
    idle(1);
    issue(32'hA082_0000, 32'h003, 32'h0000_00A5, 32'hD, 32'hE, 2, 0, 1'b0, -1, -1);
    check("sb_be", snap_be, 4'b1000);
    check("sb_wdata", snap_wdata, 32'hA5A5_A5A5);
    idle(1);
    issue(32'h8482_0000, 32'h101, 32'h0, 32'h0, 32'h0, 0, 0, 1'b0, -1, -1);
    idle(1);

    // LW timeout, then a stray ack in IDLE
    req_cycles = 0; err_pulses = 0;
    issue(32'h8C82_0000, 32'h200, 32'h0, 32'hF, 32'h10, 0, 0, 1'b0, -1, -1);
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    idle(1);
    dmem_ack = 1'b0;
    idle(1);
    check("to_req_cycles", req_cycles, TIMEOUT);
    check("to_err_pulses", err_pulses, 1);
    check("to_me_ir", me_IR, 32'hA082_0000);

    // SW flushed in ACCESS: bus completes, result discarded
    req_cycles = 0;
    issue(32'hAC82_0000, 32'h300, 32'hDEAD_BEEF, 32'h11, 32'h12, 3, 0, 1'b0, 1, -1);
    check("swf_cond", me_cond, `COND_EMPTY);
    check("swf_req_cycles", req_cycles, 3);
    check("swf_wdata", snap_wdata, 32'hDEAD_BEEF);
    idle(1);

    // Flush in IDLE, and ack coincident with flush
    req_cycles = 0; err_pulses = 0;
    issue(32'h8C82_0000, 32'h010, 32'h0, 32'h13, 32'h14, 0, 0, 1'b1, -1, -1);
    idle(1);
    check("fidle_req_cycles", req_cycles, 0);
    check("fidle_err_pulses", err_pulses, 0);
    issue(32'h8C82_0000, 32'h010, 32'h0, 32'h15, 32'h16, 2, 32'h0BAD_F00D, 1'b0, 2, -1);
    check("fack_mem", me_MEM, 32'h0000_00A5 & 32'h0);
    idle(1);

    // Non-memory after memory ops
    issue(32'h0128_5025, 32'hCAFE_0000, 32'h0, 32'h17, 32'h18, 0, 0, 1'b0, -1, -1);
    idle(1);

    // Reset in the middle of a store ACCESS
    issue(32'hAC82_0000, 32'h040, 32'h1111_2222, 32'h19, 32'h1A, 0, 0, 1'b0, -1, 2);
    check("rst_me_ir", me_IR, 32'h0);
    check("rst_req", dmem_req, 1'b0);
    idle(1);
    issue(32'h0085_1021, 32'h44, 32'h0, 32'h1B, 32'h1C, 0, 0, 1'b0, -1, -1);
    check("post_rst_z", me_Z, 32'h44);
    idle(2);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
